iiitb_countdown_timer: RTL

//  BCD HH:MM:SS countdown timer: the down-counting counterpart of the iiitb_rtc up-counter.

---
 rtl/iiitb_countdown_timer_if.sv | 33 +++
 rtl/iiitb_countdown_timer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/iiitb_countdown_timer_if.sv
// Control and display bundle for the BCD countdown timer.
// The master side loads, starts and pauses the timer; the slave side is the timer itself.
interface iiitb_countdown_timer_if;
  logic       load;
  logic [3:0] ld_hrm;
  logic [3:0] ld_hrl;
  logic [3:0] ld_minm;
  logic [3:0] ld_minl;
  logic [3:0] ld_secm;
  logic [3:0] ld_secl;
  logic       start;
  logic       pause;
  logic [3:0] hrm;
  logic [3:0] hrl;
  logic [3:0] minm;
  logic [3:0] minl;
  logic [3:0] secm;
  logic [3:0] secl;
  logic       running;
  logic       expired;
  logic       done;
  logic       load_err;

  modport master (
    output load, ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl, start, pause,
    input  hrm, hrl, minm, minl, secm, secl, running, expired, done, load_err
  );

  modport slave (
    input  load, ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl, start, pause,
    output hrm, hrl, minm, minl, secm, secl, running, expired, done, load_err
  );
endinterface

// File: rtl/iiitb_countdown_timer.sv
// BCD HH:MM:SS countdown timer clocked by the 1 Hz second_clk of the RTC.
// Loads a legal BCD time, counts down while running and flags expiry at 00:00:00.
module iiitb_countdown_timer #(
  parameter int unsigned MAX_HRM = 2,
  parameter int unsigned MAX_HR  = 23
) (
  input  logic                        second_clk,
  input  logic                        rst,
  iiitb_countdown_timer_if.slave      bus
);

  localparam int unsigned DW = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] hrm_q, hrl_q, minm_q, minl_q, secm_q, secl_q;
  logic [DW-1:0] hrm_d, hrl_d, minm_d, minl_d, secm_d, secl_d;
  logic [DW-1:0] dec_hrm, dec_hrl, dec_minm, dec_minl, dec_secm, dec_secl;
  logic          running_q, expired_q, done_q, load_err_q;
  logic          done_d, load_err_d;
  logic          ld_ok, cnt_zero, dec_zero;
  logic [7:0]    ld_hr;

  assign ld_hr = 8'(bus.ld_hrm) * 8'd10 + 8'(bus.ld_hrl);
  assign ld_ok = (bus.ld_hrm  <= DW'(MAX_HRM)) && (bus.ld_hrl  <= 4'd9) &&
                 (bus.ld_minm <= 4'd5)         && (bus.ld_minl <= 4'd9) &&
                 (bus.ld_secm <= 4'd5)         && (bus.ld_secl <= 4'd9) &&
                 (ld_hr <= 8'(MAX_HR));

  assign cnt_zero = ({hrm_q, hrl_q, minm_q, minl_q, secm_q, secl_q} == 24'd0);
  assign dec_zero = ({dec_hrm, dec_hrl, dec_minm, dec_minl, dec_secm, dec_secl} == 24'd0);

  // One-second decrement with the BCD borrow chain; only used while the count is nonzero.
  always_comb begin
    dec_hrm  = hrm_q;
    dec_hrl  = hrl_q;
    dec_minm = minm_q;
    dec_minl = minl_q;
    dec_secm = secm_q;
    dec_secl = secl_q;
    if (secl_q != 4'd0) begin
      dec_secl = secl_q - 4'd1;
    end else begin
      dec_secl = 4'd9;
      if (secm_q != 4'd0) begin
        dec_secm = secm_q - 4'd1;
      end else begin
        dec_secm = 4'd5;
        if (minl_q != 4'd0) begin
          dec_minl = minl_q - 4'd1;
        end else begin
          dec_minl = 4'd9;
          if (minm_q != 4'd0) begin
            dec_minm = minm_q - 4'd1;
          end else begin
            dec_minm = 4'd5;
            if (hrl_q != 4'd0) begin
              dec_hrl = hrl_q - 4'd1;
            end else begin
              dec_hrl = 4'd9;
              dec_hrm = hrm_q - 4'd1;
            end
          end
        end
      end
    end
  end

  // Next state and next outputs; priority load > pause > start > count.
  always_comb begin
    state_d    = state_q;
    hrm_d      = hrm_q;
    hrl_d      = hrl_q;
    minm_d     = minm_q;
    minl_d     = minl_q;
    secm_d     = secm_q;
    secl_d     = secl_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (ld_ok) begin
        state_d = ST_IDLE;
        hrm_d   = bus.ld_hrm;
        hrl_d   = bus.ld_hrl;
        minm_d  = bus.ld_minm;
        minl_d  = bus.ld_minl;
        secm_d  = bus.ld_secm;
        secl_d  = bus.ld_secl;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.pause) begin
      if (state_q == ST_RUN) state_d = ST_PAUSED;
    end else if (bus.start && !cnt_zero &&
                 ((state_q == ST_IDLE) || (state_q == ST_PAUSED))) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      hrm_d  = dec_hrm;
      hrl_d  = dec_hrl;
      minm_d = dec_minm;
      minl_d = dec_minl;
      secm_d = dec_secm;
      secl_d = dec_secl;
      if (dec_zero) begin
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge second_clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hrm_q      <= '0;
      hrl_q      <= '0;
      minm_q     <= '0;
      minl_q     <= '0;
      secm_q     <= '0;
      secl_q     <= '0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hrm_q      <= hrm_d;
      hrl_q      <= hrl_d;
      minm_q     <= minm_d;
      minl_q     <= minl_d;
      secm_q     <= secm_d;
      secl_q     <= secl_d;
      running_q  <= (state_d == ST_RUN);
      expired_q  <= (state_d == ST_EXPIRED);
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.hrm      = hrm_q;
  assign bus.hrl      = hrl_q;
  assign bus.minm     = minm_q;
  assign bus.minl     = minl_q;
  assign bus.secm     = secm_q;
  assign bus.secl     = secl_q;
  assign bus.running  = running_q;
  assign bus.expired  = expired_q;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;

endmodule
